// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package full_adder_pkg;

    localparam int unsigned FA_DEFAULT_WIDTH = 1;

    // {carry, sum} for the default-width adder.
    typedef struct packed {
        logic                        carry;
        logic [FA_DEFAULT_WIDTH-1:0] sum;
    } fa_result_t;

endpackage

// File: rtl/full_adder_1_if.sv
// Operand/result bundle for full_adder_1; master drives operands, slave returns results.
interface full_adder_1_if import full_adder_pkg::*; #(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;

    modport master (
        output in_valid, a, b, c,
        input  sum, carry, out_valid
    );

    modport slave (
        input  in_valid, a, b, c,
        output sum, carry, out_valid
    );

endinterface

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell; one link of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_1.sv
// Registered ripple-carry adder: {carry, sum} = a + b + c, one clock of latency.
module full_adder_1 import full_adder_pkg::*; #(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    full_adder_1_if.slave bus
);

    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid_q;

    assign k[0] = bus.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (k[i]),
            .s    (s[i]),
            .cout (k[i+1])
        );
    end

    // Results only move on an accepted input; idle cycles hold sum/carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q   <= s;
                carry_q <= k[WIDTH];
            end
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_1.sv
// Self-checking bench for full_adder_1 at WIDTH=1 and WIDTH=4 against an arithmetic model.
module tb_full_adder_1;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    full_adder_1_if #(.WIDTH(1)) if1 ();
    full_adder_1_if #(.WIDTH(4)) if4 ();

    full_adder_1 #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    full_adder_1 #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        if1.in_valid = v;
        if1.a        = a;
        if1.b        = b;
        if1.c        = c;
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        if4.in_valid = v;
        if4.a        = a;
        if4.b        = b;
        if4.c        = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
        #1;
        n_tests++;
        if ({if1.out_valid, if1.carry, if1.sum} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_init_w1: got %b required 000", {if1.out_valid, if1.carry, if1.sum});
        end
        n_tests++;
        if ({if4.out_valid, if4.carry, if4.sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_init_w4: got %b required 000000",
                     {if4.out_valid, if4.carry, if4.sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        drive4(1'b1, 4'h9, 4'h9, 1'b1);
        step();
        n_tests++;
        if ({if1.out_valid, if1.carry, if1.sum} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_first_capture: got %b required 111",
                     {if1.out_valid, if1.carry, if1.sum});
        end
        // Asynchronous assert, mid-cycle, no clock edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if1.out_valid, if1.carry, if1.sum} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async_w1: got %b required 000", {if1.out_valid, if1.carry, if1.sum});
        end
        n_tests++;
        if ({if4.out_valid, if4.carry, if4.sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async_w4: got %b required 000000",
                     {if4.out_valid, if4.carry, if4.sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_truth_table();
        fa_result_t exp;
        int         tot;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive1(1'b1, i[2], i[1], i[0]);
            step();
            tot = i[2] + i[1] + i[0];
            exp = fa_result_t'(tot[1:0]);
            n_tests++;
            if (if1.out_valid !== 1'b1 || if1.sum !== exp.sum || if1.carry !== exp.carry) begin
                n_fail++;
                $display("FAIL truth_%0d%0d%0d: got v%b s%b c%b required v1 s%b c%b",
                         i[2], i[1], i[0], if1.out_valid, if1.sum, if1.carry, exp.sum, exp.carry);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        n_tests++;
        if ({if1.out_valid, if1.carry, if1.sum} !== 3'b110) begin
            n_fail++;
            $display("FAIL hold_capture: got %b required 110", {if1.out_valid, if1.carry, if1.sum});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drive1(1'b0, 1'b0, 1'b0, 1'b1);
            else drive1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            step();
            n_tests++;
            if ({if1.out_valid, if1.carry, if1.sum} !== 3'b010) begin
                n_fail++;
                $display("FAIL hold_idle_%0d: got %b required 010",
                         i, {if1.out_valid, if1.carry, if1.sum});
            end
        end
    endtask

    task automatic test_ripple4();
        logic [3:0] va [2] = '{4'hF, 4'h7};
        logic [3:0] vb [2] = '{4'h0, 4'h8};
        logic       vc [2] = '{1'b1, 1'b0};
        logic [3:0] es [2] = '{4'h0, 4'hF};
        logic       ec [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive4(1'b1, va[i], vb[i], vc[i]);
            step();
            n_tests++;
            if (if4.out_valid !== 1'b1 || if4.sum !== es[i] || if4.carry !== ec[i]) begin
                n_fail++;
                $display("FAIL ripple4_%0d: got v%b s%h c%b required v1 s%h c%b",
                         i, if4.out_valid, if4.sum, if4.carry, es[i], ec[i]);
            end
        end
        @(negedge clk);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [4:0] q[$];
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] exp;
        logic [4:0] last = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            q.push_back(5'(ra) + 5'(rb) + 5'(rc));
            drive4(1'b1, ra, rb, rc);
            step();
            exp  = q.pop_front();
            last = exp;
            n_tests++;
            if (if4.out_valid !== 1'b1 || {if4.carry, if4.sum} !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v%b %h required v1 %h",
                         i, if4.out_valid, {if4.carry, if4.sum}, exp);
            end
        end
        @(negedge clk);
        drive4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        step();
        n_tests++;
        if (if4.out_valid !== 1'b0 || {if4.carry, if4.sum} !== last) begin
            n_fail++;
            $display("FAIL b2b_end: got v%b %h required v0 %h",
                     if4.out_valid, {if4.carry, if4.sum}, last);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] exp_res = '0;
        logic       exp_v   = 1'b0;
        int         bad     = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v  = (i == 0) ? 1'b1 : 1'($urandom);
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            drive4(v, ra, rb, rc);
            step();
            if (v) exp_res = 5'(ra) + 5'(rb) + 5'(rc);
            exp_v = v;
            n_tests++;
            if (if4.out_valid !== exp_v || {if4.carry, if4.sum} !== exp_res) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d: got v%b %h required v%b %h",
                             i, if4.out_valid, {if4.carry, if4.sum}, exp_v, exp_res);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive4(1'b1, 4'hF, 4'hF, 1'b1);
        #2;
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({if4.out_valid, if4.carry, if4.sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: got %b required 000000",
                     {if4.out_valid, if4.carry, if4.sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({if4.out_valid, if4.carry, if4.sum} !== 6'b0) begin
                n_fail++;
                $display("FAIL midreset_stale_%0d: got %b required 000000",
                         i, {if4.out_valid, if4.carry, if4.sum});
            end
        end
        @(negedge clk);
        drive4(1'b1, 4'h3, 4'h4, 1'b0);
        step();
        n_tests++;
        if (if4.out_valid !== 1'b1 || {if4.carry, if4.sum} !== 5'h07) begin
            n_fail++;
            $display("FAIL midreset_resume: got v%b %h required v1 07",
                     if4.out_valid, {if4.carry, if4.sum});
        end
        @(negedge clk);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_ripple4();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
